// File: rtl/classifier_stream_encoder.sv
// classifier_stream_encoder
// Readback path for the BNN classifier result. On a start request the score
// vector is snapshotted, the argmax class is found with one comparison per
// cycle, and a framed byte stream (header, scores, argmax index, XOR
// checksum) is sent back toward the host over a valid/ready byte interface.

module classifier_stream_encoder #(
    parameter int          N_CLASSES = 10,
    parameter int          SCORE_W   = 5,
    parameter logic [7:0]  HEADER    = 8'hA5,
    parameter int          IDX_W     = $clog2(N_CLASSES)
) (
    input  logic                                usb_clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [N_CLASSES-1:0][SCORE_W-1:0]   values_i,
    output logic [7:0]                          data_o,
    output logic                                valid_o,
    input  logic                                ready_i,
    output logic                                busy,
    output logic                                done,
    output logic [IDX_W-1:0]                    class_o
);

    // The argmax counter has to reach N_CLASSES itself (one past the last
    // class) so that the ARGMAX state lasts exactly N_CLASSES cycles.
    localparam int CNT_W = $clog2(N_CLASSES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGMAX,
        S_HDR,
        S_SCORE,
        S_IDX,
        S_CHK
    } state_t;

    state_t                               state;
    state_t                               next_state;

    logic [N_CLASSES-1:0][SCORE_W-1:0]    snapshot;
    logic [IDX_W-1:0]                     best_idx;
    logic [SCORE_W-1:0]                   best_val;
    logic [CNT_W-1:0]                     arg_cnt;
    logic [IDX_W-1:0]                     byte_cnt;
    logic [7:0]                           chk;

    logic                                 handshake;
    logic                                 argmax_last;
    logic                                 score_last;
    logic [SCORE_W-1:0]                   cur_score;

    assign handshake   = valid_o && ready_i;
    assign argmax_last = (arg_cnt == CNT_W'(N_CLASSES));
    assign score_last  = (byte_cnt == IDX_W'(N_CLASSES - 1));
    assign cur_score   = snapshot[arg_cnt[IDX_W-1:0]];

    // State register; reset abandons any frame in flight immediately.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: byte states only move forward on a handshake.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_ARGMAX;
                end
            end
            S_ARGMAX: begin
                if (argmax_last) begin
                    next_state = S_HDR;
                end
            end
            S_HDR: begin
                if (handshake) begin
                    next_state = S_SCORE;
                end
            end
            S_SCORE: begin
                if (handshake && score_last) begin
                    next_state = S_IDX;
                end
            end
            S_IDX: begin
                if (handshake) begin
                    next_state = S_CHK;
                end
            end
            S_CHK: begin
                if (handshake) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Stream outputs are decoded from the state and held registers, so the
    // byte on data_o cannot change while the sink is stalling.
    always_comb begin
        valid_o = 1'b0;
        data_o  = 8'h00;
        busy    = (state != S_IDLE);
        case (state)
            S_HDR: begin
                valid_o = 1'b1;
                data_o  = HEADER;
            end
            S_SCORE: begin
                valid_o = 1'b1;
                data_o  = 8'(snapshot[byte_cnt]);
            end
            S_IDX: begin
                valid_o = 1'b1;
                data_o  = 8'(best_idx);
            end
            S_CHK: begin
                valid_o = 1'b1;
                data_o  = chk;
            end
            default: begin
                valid_o = 1'b0;
                data_o  = 8'h00;
            end
        endcase
    end

    // Snapshot capture and the serial argmax scan, one class per cycle;
    // a strict greater-than keeps the lowest index on ties.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
            best_idx <= '0;
            best_val <= '0;
            arg_cnt  <= '0;
            class_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snapshot <= values_i;
                        best_idx <= '0;
                        best_val <= values_i[0];
                        arg_cnt  <= CNT_W'(1);
                    end
                end
                S_ARGMAX: begin
                    if (!argmax_last) begin
                        if (cur_score > best_val) begin
                            best_idx <= arg_cnt[IDX_W-1:0];
                            best_val <= cur_score;
                        end
                        arg_cnt <= arg_cnt + CNT_W'(1);
                    end else begin
                        class_o <= best_idx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Score byte counter, running checksum and the end-of-frame done pulse.
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            chk      <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        byte_cnt <= '0;
                        chk      <= 8'h00;
                    end
                end
                S_HDR, S_IDX: begin
                    if (handshake) begin
                        chk <= chk ^ data_o;
                    end
                end
                S_SCORE: begin
                    if (handshake) begin
                        chk      <= chk ^ data_o;
                        byte_cnt <= byte_cnt + IDX_W'(1);
                    end
                end
                S_CHK: begin
                    if (handshake) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_classifier_stream_encoder.sv
// tb_classifier_stream_encoder
// Randomised self-checking bench: a reference model builds the expected
// frame from the argmax/XOR rules and each test task compares the collected
// byte stream, latency, done pulses and class output against it.

module tb_classifier_stream_encoder;

    localparam int N  = 10;
    localparam int W  = 5;
    localparam int NB = N + 3;

    typedef logic [N-1:0][W-1:0] scores_t;

    logic         usb_clk;
    logic         rst;
    logic         start;
    scores_t      values_i;
    logic [7:0]   data_o;
    logic         valid_o;
    logic         ready_i;
    logic         busy;
    logic         done;
    logic [3:0]   class_o;

    int           checks;
    int           errors;

    logic [7:0]   exp_bytes [NB];
    int           exp_idx;

    logic [7:0]   got [$];
    int           latency;
    int           done_cnt;
    int           unstable;
    int           post_busy;
    bit           timed_out;

    classifier_stream_encoder dut (
        .usb_clk  (usb_clk),
        .rst      (rst),
        .start    (start),
        .values_i (values_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy     (busy),
        .done     (done),
        .class_o  (class_o)
    );

    // Free-running clock, first rising edge at 5 ns.
    initial begin
        usb_clk = 1'b0;
        forever #5 usb_clk = ~usb_clk;
    end

    // Reference model: first index holding the maximum score, bytes framed
    // as header, scores, index and XOR of everything before it.
    task automatic compute_expected(input scores_t s);
        int         best;
        logic [7:0] x;
        best = 0;
        for (int j = 1; j < N; j++) begin
            if (s[j] > s[best]) best = j;
        end
        exp_idx      = best;
        exp_bytes[0] = 8'hA5;
        for (int j = 0; j < N; j++) exp_bytes[j + 1] = 8'(s[j]);
        exp_bytes[N + 1] = 8'(best);
        x = 8'h00;
        for (int k = 0; k < N + 2; k++) x = x ^ exp_bytes[k];
        exp_bytes[N + 2] = x;
    endtask

    // Requests one frame and records what the sink sees; no checking here.
    task automatic run_frame(input scores_t s, input bit rand_ready,
                             input bit mutate, input int restart_at);
        int         edges;
        int         post;
        bit         seen_valid;
        bit         pv;
        bit         pr;
        logic [7:0] pd;
        got.delete();
        latency   = -1;
        done_cnt  = 0;
        unstable  = 0;
        post_busy = 0;
        timed_out = 1'b0;
        @(posedge usb_clk); #1;
        values_i = s;
        start    = 1'b1;
        ready_i  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge usb_clk); #1;
        start      = 1'b0;
        edges      = 0;
        post       = -1;
        seen_valid = 1'b0;
        pv         = 1'b0;
        pr         = 1'b0;
        pd         = 8'h00;
        forever begin
            @(negedge usb_clk);
            if (valid_o && !seen_valid) begin
                seen_valid = 1'b1;
                latency    = edges;
            end
            if (pv && !pr && (!valid_o || data_o !== pd)) unstable++;
            if (valid_o && ready_i) got.push_back(data_o);
            if (done) done_cnt++;
            if (post >= 0 && (busy || valid_o)) post_busy++;
            pv = valid_o;
            pr = ready_i;
            pd = data_o;
            if (done && post < 0) post = 0;
            if (post >= 0) begin
                post++;
                if (post > N + 5) break;
            end
            if (edges > 400) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge usb_clk); #1;
            edges++;
            if (rand_ready) ready_i = 1'($urandom_range(0, 1));
            if (mutate && got.size() == 3) values_i = scores_t'({$urandom, $urandom});
            start = (restart_at >= 0 && got.size() == restart_at) ? 1'b1 : 1'b0;
        end
        start   = 1'b0;
        ready_i = 1'b0;
    endtask

    // Asynchronous reset must clear every output without a clock edge.
    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (class_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_class: got %0d expected 0", class_o); end
        repeat (2) @(posedge usb_clk);
        @(negedge usb_clk);
        rst = 1'b0;
    endtask

    // Hand-picked frames with always-ready sink: single peak, tie, all zero.
    task automatic test_known_frames();
        scores_t    s;
        logic [7:0] obs;
        int         want_cls [3];
        logic [7:0] want_chk [3];
        want_cls = '{7, 2, 0};
        want_chk = '{8'hB6, 8'hA7, 8'hA5};
        for (int t = 0; t < 3; t++) begin
            s = '0;
            if (t == 0) s[7] = 5'd20;
            if (t == 1) begin s[2] = 5'd31; s[5] = 5'd31; end
            compute_expected(s);
            run_frame(s, 1'b0, 1'b0, -1);
            checks++; if (timed_out) begin errors++; $display("[TB] FAIL known%0d_timeout: frame did not finish", t); end
            checks++; if (latency != N) begin errors++; $display("[TB] FAIL known%0d_latency: got %0d expected %0d", t, latency, N); end
            checks++; if (got.size() != NB) begin errors++; $display("[TB] FAIL known%0d_len: got %0d expected %0d", t, got.size(), NB); end
            for (int k = 0; k < NB; k++) begin
                obs = (k < got.size()) ? got[k] : 8'hxx;
                checks++; if (obs !== exp_bytes[k]) begin errors++; $display("[TB] FAIL known%0d_byte%0d: got %h expected %h", t, k, obs, exp_bytes[k]); end
            end
            obs = (got.size() == NB) ? got[NB - 1] : 8'hxx;
            checks++; if (obs !== want_chk[t]) begin errors++; $display("[TB] FAIL known%0d_chk: got %h expected %h", t, obs, want_chk[t]); end
            checks++; if (class_o !== 4'(want_cls[t])) begin errors++; $display("[TB] FAIL known%0d_class: got %0d expected %0d", t, class_o, want_cls[t]); end
            checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL known%0d_done: got %0d pulses expected 1", t, done_cnt); end
        end
    endtask

    // Random sink stalls and input changes mid-frame must not alter the frame.
    task automatic test_backpressure();
        scores_t    s;
        logic [7:0] obs;
        for (int t = 0; t < 6; t++) begin
            if (t == 0) begin
                s = '0;
                s[7] = 5'd20;
            end else begin
                for (int j = 0; j < N; j++) s[j] = (t % 2 == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            end
            compute_expected(s);
            run_frame(s, 1'b1, 1'b1, -1);
            checks++; if (timed_out) begin errors++; $display("[TB] FAIL bp%0d_timeout: frame did not finish", t); end
            checks++; if (latency != N) begin errors++; $display("[TB] FAIL bp%0d_latency: got %0d expected %0d", t, latency, N); end
            checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL bp%0d_stable: %0d stalled cycles changed, expected 0", t, unstable); end
            checks++; if (got.size() != NB) begin errors++; $display("[TB] FAIL bp%0d_len: got %0d expected %0d", t, got.size(), NB); end
            for (int k = 0; k < NB; k++) begin
                obs = (k < got.size()) ? got[k] : 8'hxx;
                checks++; if (obs !== exp_bytes[k]) begin errors++; $display("[TB] FAIL bp%0d_byte%0d: got %h expected %h", t, k, obs, exp_bytes[k]); end
            end
            checks++; if (class_o !== 4'(exp_idx)) begin errors++; $display("[TB] FAIL bp%0d_class: got %0d expected %0d", t, class_o, exp_idx); end
            checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL bp%0d_done: got %0d pulses expected 1", t, done_cnt); end
        end
    endtask

    // A start pulse during the score bytes is dropped, not queued.
    task automatic test_start_while_busy();
        scores_t    s;
        logic [7:0] obs;
        for (int j = 0; j < N; j++) s[j] = 5'($urandom_range(0, 31));
        compute_expected(s);
        run_frame(s, 1'b0, 1'b0, 5);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL busy_timeout: frame did not finish"); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL busy_done: got %0d pulses expected 1", done_cnt); end
        checks++; if (post_busy != 0) begin errors++; $display("[TB] FAIL busy_queued: %0d busy cycles after done expected 0", post_busy); end
        checks++; if (got.size() != NB) begin errors++; $display("[TB] FAIL busy_len: got %0d expected %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            obs = (k < got.size()) ? got[k] : 8'hxx;
            checks++; if (obs !== exp_bytes[k]) begin errors++; $display("[TB] FAIL busy_byte%0d: got %h expected %h", k, obs, exp_bytes[k]); end
        end
    endtask

    // Reset during byte 5 abandons the frame; the next frame is complete and
    // carries a checksum that owes nothing to the aborted one.
    task automatic test_reset_mid_frame();
        scores_t    s;
        logic [7:0] obs;
        int         cnt;
        int         n;
        s = '0;
        s[3] = 5'd9;
        @(posedge usb_clk); #1;
        values_i = s;
        start    = 1'b1;
        ready_i  = 1'b1;
        @(posedge usb_clk); #1;
        start = 1'b0;
        cnt   = 0;
        n     = 0;
        while (cnt < 5 && n < 100) begin
            @(negedge usb_clk);
            if (valid_o && ready_i) cnt++;
            n++;
        end
        @(negedge usb_clk);
        checks++; if (valid_o !== 1'b1 || class_o !== 4'd3) begin errors++; $display("[TB] FAIL abort_pre: valid %b class %0d expected 1 and 3", valid_o, class_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_clear: valid %b busy %b expected 0 0", valid_o, busy); end
        checks++; if (data_o !== 8'h00 || class_o !== 4'd0) begin errors++; $display("[TB] FAIL abort_data: data %h class %0d expected 00 and 0", data_o, class_o); end
        ready_i = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge usb_clk);
            if (done) cnt++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge usb_clk);
            if (done || busy) cnt++;
        end
        checks++; if (cnt != 0) begin errors++; $display("[TB] FAIL abort_done: %0d done/busy cycles expected 0", cnt); end
        for (int j = 0; j < N; j++) s[j] = 5'($urandom_range(0, 31));
        compute_expected(s);
        run_frame(s, 1'b1, 1'b0, -1);
        checks++; if (timed_out) begin errors++; $display("[TB] FAIL after_timeout: frame did not finish"); end
        checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL after_done: got %0d pulses expected 1", done_cnt); end
        checks++; if (got.size() != NB) begin errors++; $display("[TB] FAIL after_len: got %0d expected %0d", got.size(), NB); end
        for (int k = 0; k < NB; k++) begin
            obs = (k < got.size()) ? got[k] : 8'hxx;
            checks++; if (obs !== exp_bytes[k]) begin errors++; $display("[TB] FAIL after_byte%0d: got %h expected %h", k, obs, exp_bytes[k]); end
        end
        checks++; if (class_o !== 4'(exp_idx)) begin errors++; $display("[TB] FAIL after_class: got %0d expected %0d", class_o, exp_idx); end
    endtask

    // Sequence of scenarios followed by the single summary line.
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        ready_i  = 1'b0;
        values_i = '0;
        test_reset();
        test_known_frames();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
